rf_write_arbiter: RTL and testbench
===================================

Name: rf_write_arbiter

Overview:
- Shares the single write port of the 8x8 register file between two writeback sources: ALU result (ALU) and data-memory load result (MEM).
- Each source has a 1-entry holding slot, and an oldest-first arbiter grants at most one register write per clock.
- Exports a pending-write scoreboard and read-hazard flags so the control unit can stall operand reads whose target write is still queued.
- Sits between the execute/memory stages and the register file's IN/INADDRESS/WRITE inputs.

Parameters:
- DATA_W, 8, register data width
- ADDR_W, 3, register address width
- NREGS, 8, number of registers (2**ADDR_W)
- CNT_W, 8, width of the conflict counter

Ports:
- CLK  in  1  clock
- RESET  in  1  synchronous, active-high reset
- ALU_VALID  in  1  ALU write request
- ALU_ADDR  in  ADDR_W  ALU destination register
- ALU_DATA  in  DATA_W  ALU result
- ALU_READY  out  1  ALU slot can accept
- MEM_VALID  in  1  load write request
- MEM_ADDR  in  ADDR_W  load destination register
- MEM_DATA  in  DATA_W  loaded data
- MEM_READY  out  1  MEM slot can accept
- RD1_ADDR  in  ADDR_W  operand-1 read address
- RD2_ADDR  in  ADDR_W  operand-2 read address
- RF_WRITE  out  1  write enable to register file
- RF_INADDRESS  out  ADDR_W  write address to register file
- RF_IN  out  DATA_W  write data to register file
- PEND  out  NREGS  bit i = a queued write targets register i
- RD1_HAZ  out  1  RD1_ADDR has a queued write
- RD2_HAZ  out  1  RD2_ADDR has a queued write
- CONFLICT_CNT  out  CNT_W  saturating count of cycles with both slots full

Behaviour:
- Reset: RESET is synchronous, active-high; clock is CLK. At a posedge with RESET=1:
  - both slots are emptied; incoming requests are discarded.
  - age bit clears and CONFLICT_CNT is 0.
  - Resulting outputs: RF_WRITE=0, RF_INADDRESS=0, RF_IN=0, PEND=0, RD1_HAZ=RD2_HAZ=0, ALU_READY=MEM_READY=1.
  - Applies mid-operation: queued writes are lost, not committed.
- Handshake:
  - X_READY = slot X empty OR slot X granted this cycle.
  - A request is accepted at a posedge where X_VALID=1 and X_READY=1; addr/data are captured into the slot.
  - A source must hold VALID/ADDR/DATA stable until accepted.
- Slot state: per slot, EMPTY/FULL. EMPTY->FULL on accept. FULL->EMPTY on grant without accept. FULL->FULL on grant with simultaneous accept (back-to-back, one write per cycle per source).
- Arbitration (combinational from slot state):
  - One slot full: that slot wins.
  - Both full: the older wins, tracked by an age bit set on fill order.
  - Both filled on the same edge: MEM is older.
- Commit:
  - RF_WRITE=1, RF_INADDRESS and RF_IN come from the winning slot, all combinational.
  - The register file samples at the next posedge; the winning slot clears on that same edge.
  - If no slot is full, RF_WRITE=0 and RF_INADDRESS/RF_IN are 0.
- Latency:
  - Accept at edge N -> RF_WRITE high during cycle N..N+1 -> committed at edge N+1 if uncontested.
  - A contested loser commits at edge N+2.
- Ordering:
  - Same-address writes from both sources commit in acceptance order, so the later-accepted value persists.
  - Same-edge acceptance of the same address: MEM commits first, ALU value persists.
- Scoreboard:
  - PEND = OR of one-hot(addr) over full slots.
  - RD1_HAZ = PEND[RD1_ADDR]; RD2_HAZ = PEND[RD2_ADDR].
  - Combinational; a slot being committed this cycle still counts as pending.
- CONFLICT_CNT: increments at each posedge where both slots are full and RESET=0; saturates at 2**CNT_W-1.
- Throughput: at most 1 register write per cycle; the sustained aggregate accept rate is therefore 1 per cycle.

Decomposition:
- Shared package rf_arb_pkg holds:
  - DATA_W/ADDR_W/NREGS defaults.
  - Source encodings SRC_ALU=1'b0, SRC_MEM=1'b1.
  - Slot state encodings SLOT_EMPTY=1'b0, SLOT_FULL=1'b1.
- Sub-module wb_slot: one-entry holding register with accept/grant/clear, instantiated twice (ALU, MEM).
- Arbiter, age bit, scoreboard and counter stay in the top module.

Test Plan:
- Reset mid-operation: fill both slots with ALU(r2=0x11) and MEM(r5=0x22), assert RESET one cycle -> RF_WRITE=0, PEND=0x00, both READY=1, CONFLICT_CNT=0, no write to r2/r5.
- Single ALU write: ALU_VALID with r3=0xA5 accepted at edge N -> during the next cycle RF_WRITE=1, RF_INADDRESS=3, RF_IN=0xA5, PEND=0x08; after edge N+1, PEND=0x00.
- Same-edge contest: ALU r1=0x10 and MEM r4=0x40 accepted together -> edge N+1 writes r4=0x40 (MEM older), edge N+2 writes r1=0x10, CONFLICT_CNT=1.
- Same-address order: MEM r6=0x77 accepted at edge N, ALU r6=0x99 at edge N+1 -> commits in order 0x77 then 0x99; final r6=0x99.
- Back-to-back stream: ALU_VALID held for 4 cycles with r0..r3 and MEM idle -> ALU_READY stays 1, one write per cycle, 4 consecutive RF_WRITE cycles.
- Hazard/saturation: MEM slot holds r7 and RD1_ADDR=7, RD2_ADDR=2 -> RD1_HAZ=1, RD2_HAZ=0. Keep both slots full via continuous requests for 300 cycles -> CONFLICT_CNT=255.

Source files
------------

// File: rtl/rf_arb_pkg.sv
// Shared definitions for the register-file write arbiter: width defaults,
// source identifiers and holding-slot state encodings.
package rf_arb_pkg;

  localparam int RF_DATA_W = 8;
  localparam int RF_ADDR_W = 3;
  localparam int RF_NREGS  = 1 << RF_ADDR_W;
  localparam int RF_CNT_W  = 8;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } src_e;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_e;

endpackage

// File: rtl/rf_write_arbiter_wb_slot.sv
// One-entry writeback holding slot: accepts a register write when empty or
// when its current entry is being granted this cycle.
module wb_slot
  import rf_arb_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              i_valid,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_grant,
  output logic              o_ready,
  output logic              o_accept,
  output logic              o_full,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_data
);

  slot_e             r_state;
  slot_e             w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;

  assign o_full   = (r_state == SLOT_FULL);
  assign o_ready  = ~o_full | i_grant;
  assign o_accept = i_valid & o_ready;
  assign o_addr   = r_addr;
  assign o_data   = r_data;

  always_ff @(posedge CLK) begin
    if (RESET) r_state <= SLOT_EMPTY;
    else       r_state <= w_state_nxt;
  end

  // A grant with a simultaneous accept keeps the slot full (back-to-back).
  always_comb begin
    w_state_nxt = r_state;
    if (o_accept)     w_state_nxt = SLOT_FULL;
    else if (i_grant) w_state_nxt = SLOT_EMPTY;
  end

  always_ff @(posedge CLK) begin
    if (o_accept) begin
      r_addr <= i_addr;
      r_data <= i_data;
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Arbitrates the single register-file write port between ALU and MEM
// writeback slots (oldest first) and exports a pending-write scoreboard.
module rf_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int NREGS  = RF_NREGS,
  parameter int CNT_W  = RF_CNT_W
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              ALU_VALID,
  input  logic [ADDR_W-1:0] ALU_ADDR,
  input  logic [DATA_W-1:0] ALU_DATA,
  output logic              ALU_READY,
  input  logic              MEM_VALID,
  input  logic [ADDR_W-1:0] MEM_ADDR,
  input  logic [DATA_W-1:0] MEM_DATA,
  output logic              MEM_READY,
  input  logic [ADDR_W-1:0] RD1_ADDR,
  input  logic [ADDR_W-1:0] RD2_ADDR,
  output logic              RF_WRITE,
  output logic [ADDR_W-1:0] RF_INADDRESS,
  output logic [DATA_W-1:0] RF_IN,
  output logic [NREGS-1:0]  PEND,
  output logic              RD1_HAZ,
  output logic              RD2_HAZ,
  output logic [CNT_W-1:0]  CONFLICT_CNT
);

  logic              w_alu_full, w_alu_accept, w_alu_grant;
  logic [ADDR_W-1:0] w_alu_addr;
  logic [DATA_W-1:0] w_alu_data;
  logic              w_mem_full, w_mem_accept, w_mem_grant;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_data;
  logic              w_any_full;
  src_e              w_win_src;
  logic [NREGS-1:0]  w_pend;
  logic              r_mem_older;
  logic [CNT_W-1:0]  r_conflict_cnt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  wb_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_alu_slot (
    .CLK      (CLK),
    .RESET    (RESET),
    .i_valid  (ALU_VALID),
    .i_addr   (ALU_ADDR),
    .i_data   (ALU_DATA),
    .i_grant  (w_alu_grant),
    .o_ready  (ALU_READY),
    .o_accept (w_alu_accept),
    .o_full   (w_alu_full),
    .o_addr   (w_alu_addr),
    .o_data   (w_alu_data)
  );

  wb_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mem_slot (
    .CLK      (CLK),
    .RESET    (RESET),
    .i_valid  (MEM_VALID),
    .i_addr   (MEM_ADDR),
    .i_data   (MEM_DATA),
    .i_grant  (w_mem_grant),
    .o_ready  (MEM_READY),
    .o_accept (w_mem_accept),
    .o_full   (w_mem_full),
    .o_addr   (w_mem_addr),
    .o_data   (w_mem_data)
  );

  assign w_any_full  = w_alu_full | w_mem_full;
  assign w_mem_grant = w_mem_full & (~w_alu_full | r_mem_older);
  assign w_alu_grant = w_alu_full & ~w_mem_grant;
  assign w_win_src   = w_mem_grant ? SRC_MEM : SRC_ALU;

  // Write is suppressed during reset so queued entries are dropped, not committed.
  always_comb begin
    RF_WRITE     = 1'b0;
    RF_INADDRESS = '0;
    RF_IN        = '0;
    if (w_any_full && !RESET) begin
      RF_WRITE = 1'b1;
      if (w_win_src == SRC_MEM) begin
        RF_INADDRESS = w_mem_addr;
        RF_IN        = w_mem_data;
      end else begin
        RF_INADDRESS = w_alu_addr;
        RF_IN        = w_alu_data;
      end
    end
  end

  always_comb begin
    w_pend = '0;
    if (w_alu_full) w_pend[w_alu_addr] = 1'b1;
    if (w_mem_full) w_pend[w_mem_addr] = 1'b1;
  end

  assign PEND         = w_pend;
  assign RD1_HAZ      = w_pend[RD1_ADDR];
  assign RD2_HAZ      = w_pend[RD2_ADDR];
  assign CONFLICT_CNT = r_conflict_cnt;

  // A fresh ALU fill makes any resident MEM entry older; a same-edge double fill
  // also lands here, leaving MEM older.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_mem_older    <= 1'b0;
      r_conflict_cnt <= '0;
    end else begin
      if (w_alu_accept)      r_mem_older <= 1'b1;
      else if (w_mem_accept) r_mem_older <= 1'b0;
      if (w_alu_full && w_mem_full) r_conflict_cnt <= sat_inc(r_conflict_cnt);
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: directed vector table, hand
// sequences for multi-cycle corners, and randomized traffic against a model.
module tb_rf_write_arbiter;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       ALU_VALID, MEM_VALID;
  logic [2:0] ALU_ADDR, MEM_ADDR, RD1_ADDR, RD2_ADDR;
  logic [7:0] ALU_DATA, MEM_DATA;
  logic       ALU_READY, MEM_READY, RF_WRITE, RD1_HAZ, RD2_HAZ;
  logic [2:0] RF_INADDRESS;
  logic [7:0] RF_IN, PEND, CONFLICT_CNT;

  always #5 CLK = ~CLK;

  rf_write_arbiter dut (
    .CLK(CLK), .RESET(RESET),
    .ALU_VALID(ALU_VALID), .ALU_ADDR(ALU_ADDR), .ALU_DATA(ALU_DATA), .ALU_READY(ALU_READY),
    .MEM_VALID(MEM_VALID), .MEM_ADDR(MEM_ADDR), .MEM_DATA(MEM_DATA), .MEM_READY(MEM_READY),
    .RD1_ADDR(RD1_ADDR), .RD2_ADDR(RD2_ADDR),
    .RF_WRITE(RF_WRITE), .RF_INADDRESS(RF_INADDRESS), .RF_IN(RF_IN),
    .PEND(PEND), .RD1_HAZ(RD1_HAZ), .RD2_HAZ(RD2_HAZ), .CONFLICT_CNT(CONFLICT_CNT)
  );

  // Register file as seen through the write port.
  logic [7:0] dut_rf [8] = '{default: 8'h00};
  always @(posedge CLK) if (RF_WRITE) dut_rf[RF_INADDRESS] <= RF_IN;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: index 0 = ALU, 1 = MEM; age is the edge number of the fill.
  bit         m_full [2];
  logic [2:0] m_addr [2];
  logic [7:0] m_data [2];
  int         m_ts   [2];
  bit         m_acc  [2];
  int         m_cnt = 0;
  int         m_t   = 0;
  logic [7:0] m_rf   [8] = '{default: 8'h00};

  task automatic step();
    int         w;
    logic [7:0] ep;
    bit         rdy [2];
    bit         rst;
    bit         vld [2];
    logic [2:0] ia [2];
    logic [7:0] id [2];
    @(negedge CLK);
    w = -1;
    if (m_full[0] && m_full[1]) w = (m_ts[1] <= m_ts[0]) ? 1 : 0;
    else if (m_full[1])         w = 1;
    else if (m_full[0])         w = 0;
    ep = 8'h00;
    for (int i = 0; i < 2; i++) if (m_full[i]) ep[m_addr[i]] = 1'b1;
    rdy[0] = !m_full[0] || (w == 0);
    rdy[1] = !m_full[1] || (w == 1);
    rst = RESET;
    check("rf_write", 32'(RF_WRITE), 32'(w >= 0 && !rst));
    if (w >= 0 && !rst) begin
      check("rf_inaddress", 32'(RF_INADDRESS), 32'(m_addr[w]));
      check("rf_in", 32'(RF_IN), 32'(m_data[w]));
    end else begin
      check("rf_inaddress_idle", 32'(RF_INADDRESS), 32'h0);
      check("rf_in_idle", 32'(RF_IN), 32'h0);
    end
    check("pend", 32'(PEND), 32'(ep));
    check("rd1_haz", 32'(RD1_HAZ), 32'(ep[RD1_ADDR]));
    check("rd2_haz", 32'(RD2_HAZ), 32'(ep[RD2_ADDR]));
    check("alu_ready", 32'(ALU_READY), 32'(rdy[0]));
    check("mem_ready", 32'(MEM_READY), 32'(rdy[1]));
    check("conflict_cnt", 32'(CONFLICT_CNT), 32'(m_cnt));
    vld[0] = ALU_VALID; ia[0] = ALU_ADDR; id[0] = ALU_DATA;
    vld[1] = MEM_VALID; ia[1] = MEM_ADDR; id[1] = MEM_DATA;
    @(posedge CLK);
    for (int i = 0; i < 2; i++) m_acc[i] = !rst && vld[i] && rdy[i];
    if (rst) begin
      m_full[0] = 0; m_full[1] = 0; m_cnt = 0;
    end else begin
      if (m_full[0] && m_full[1] && m_cnt < 255) m_cnt++;
      if (w >= 0) begin
        m_rf[m_addr[w]] = m_data[w];
        m_full[w] = 0;
      end
      for (int i = 0; i < 2; i++)
        if (m_acc[i]) begin
          m_full[i] = 1; m_addr[i] = ia[i]; m_data[i] = id[i]; m_ts[i] = m_t;
        end
    end
    m_t++;
    #1;
  endtask

  task automatic idle_inputs();
    ALU_VALID = 1'b0; ALU_ADDR = 3'd0; ALU_DATA = 8'h00;
    MEM_VALID = 1'b0; MEM_ADDR = 3'd0; MEM_DATA = 8'h00;
  endtask

  typedef struct {
    logic       rst;
    logic       av; logic [2:0] aa; logic [7:0] ad;
    logic       mv; logic [2:0] ma; logic [7:0] md;
    logic       ew; logic [2:0] ea; logic [7:0] ed;
    logic [7:0] ep; logic [7:0] ec;
  } vec_t;

  vec_t vecs [9];
  int   nwr;

  initial begin
    // inputs applied for one edge, expected outputs in the following cycle
    vecs[0] = '{1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 8'h00, 8'd0};
    vecs[1] = '{1'b0, 1'b1, 3'd3, 8'hA5, 1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 8'hA5, 8'h08, 8'd0};
    vecs[2] = '{1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 8'h00, 8'd0};
    vecs[3] = '{1'b0, 1'b1, 3'd1, 8'h10, 1'b1, 3'd4, 8'h40, 1'b1, 3'd4, 8'h40, 8'h12, 8'd0};
    vecs[4] = '{1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b1, 3'd1, 8'h10, 8'h02, 8'd1};
    vecs[5] = '{1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 8'h00, 8'd1};
    vecs[6] = '{1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 3'd6, 8'h77, 1'b1, 3'd6, 8'h77, 8'h40, 8'd1};
    vecs[7] = '{1'b0, 1'b1, 3'd6, 8'h99, 1'b0, 3'd0, 8'h00, 1'b1, 3'd6, 8'h99, 8'h40, 8'd1};
    vecs[8] = '{1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 8'h00, 8'd1};

    idle_inputs();
    RD1_ADDR = 3'd0; RD2_ADDR = 3'd0;
    RESET = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b0;
    check("reset_rf_write", 32'(RF_WRITE), 32'h0);
    check("reset_pend", 32'(PEND), 32'h0);
    check("reset_alu_ready", 32'(ALU_READY), 32'h1);
    check("reset_mem_ready", 32'(MEM_READY), 32'h1);
    check("reset_cnt", 32'(CONFLICT_CNT), 32'h0);

    // Reset while both slots hold entries: nothing reaches the register file.
    ALU_VALID = 1'b1; ALU_ADDR = 3'd2; ALU_DATA = 8'h11;
    MEM_VALID = 1'b1; MEM_ADDR = 3'd5; MEM_DATA = 8'h22;
    step();
    idle_inputs();
    check("midrst_pend_before", 32'(PEND), 32'h24);
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    check("midrst_rf_write", 32'(RF_WRITE), 32'h0);
    check("midrst_pend", 32'(PEND), 32'h0);
    check("midrst_alu_ready", 32'(ALU_READY), 32'h1);
    check("midrst_mem_ready", 32'(MEM_READY), 32'h1);
    check("midrst_cnt", 32'(CONFLICT_CNT), 32'h0);
    check("midrst_r2", 32'(dut_rf[2]), 32'h0);
    check("midrst_r5", 32'(dut_rf[5]), 32'h0);

    foreach (vecs[i]) begin
      RESET = vecs[i].rst;
      ALU_VALID = vecs[i].av; ALU_ADDR = vecs[i].aa; ALU_DATA = vecs[i].ad;
      MEM_VALID = vecs[i].mv; MEM_ADDR = vecs[i].ma; MEM_DATA = vecs[i].md;
      step();
      RESET = 1'b0;
      idle_inputs();
      check($sformatf("vec%0d_write", i), 32'(RF_WRITE), 32'(vecs[i].ew));
      check($sformatf("vec%0d_addr", i), 32'(RF_INADDRESS), 32'(vecs[i].ea));
      check($sformatf("vec%0d_data", i), 32'(RF_IN), 32'(vecs[i].ed));
      check($sformatf("vec%0d_pend", i), 32'(PEND), 32'(vecs[i].ep));
      check($sformatf("vec%0d_cnt", i), 32'(CONFLICT_CNT), 32'(vecs[i].ec));
    end
    check("order_r6", 32'(dut_rf[6]), 32'h99);
    check("order_r4", 32'(dut_rf[4]), 32'h40);
    check("order_r1", 32'(dut_rf[1]), 32'h10);
    check("single_r3", 32'(dut_rf[3]), 32'hA5);

    // Back-to-back ALU stream into r0..r3.
    nwr = 0;
    for (int i = 0; i < 4; i++) begin
      ALU_VALID = 1'b1; ALU_ADDR = 3'(i); ALU_DATA = 8'hB0 + 8'(i);
      step();
      check("stream_alu_ready", 32'(ALU_READY), 32'h1);
      check("stream_addr", 32'(RF_INADDRESS), 32'(i));
      if (RF_WRITE) nwr++;
    end
    idle_inputs();
    step();
    check("stream_writes", 32'(nwr), 32'd4);
    check("stream_drained", 32'(RF_WRITE), 32'h0);
    check("stream_r2", 32'(dut_rf[2]), 32'hB2);

    // Hazard flags against a queued MEM write to r7.
    RD1_ADDR = 3'd7; RD2_ADDR = 3'd2;
    MEM_VALID = 1'b1; MEM_ADDR = 3'd7; MEM_DATA = 8'h5A;
    step();
    idle_inputs();
    check("haz_rd1", 32'(RD1_HAZ), 32'h1);
    check("haz_rd2", 32'(RD2_HAZ), 32'h0);
    check("haz_pend", 32'(PEND), 32'h80);
    step();
    check("haz_rd1_clear", 32'(RD1_HAZ), 32'h0);

    // Saturation: both sources request continuously.
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    ALU_VALID = 1'b1; ALU_ADDR = 3'd1; ALU_DATA = 8'h01;
    MEM_VALID = 1'b1; MEM_ADDR = 3'd2; MEM_DATA = 8'h02;
    repeat (300) step();
    check("sat_cnt", 32'(CONFLICT_CNT), 32'd255);
    idle_inputs();
    repeat (3) step();
    check("sat_cnt_hold", 32'(CONFLICT_CNT), 32'd255);

    // Randomized traffic; a source holds its request until accepted.
    for (int k = 0; k < 600; k++) begin
      if (!ALU_VALID || m_acc[0]) begin
        ALU_VALID = 1'($urandom_range(0, 1));
        ALU_ADDR  = 3'($urandom);
        ALU_DATA  = 8'($urandom);
      end
      if (!MEM_VALID || m_acc[1]) begin
        MEM_VALID = 1'($urandom_range(0, 1));
        MEM_ADDR  = 3'($urandom);
        MEM_DATA  = 8'($urandom);
      end
      RD1_ADDR = 3'($urandom);
      RD2_ADDR = 3'($urandom);
      RESET = ($urandom_range(0, 59) == 0);
      step();
    end
    RESET = 1'b0;
    idle_inputs();
    repeat (3) step();
    for (int i = 0; i < 8; i++) check($sformatf("final_r%0d", i), 32'(dut_rf[i]), 32'(m_rf[i]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
